// File: rtl/pol2rec_pkg.sv
// pol2rec_pkg: shared constants, FSM state encoding and bus payload types
// for the polar-to-rectangular CORDIC rotator.
package pol2rec_pkg;

    localparam int unsigned DATA_W = 32;   // 16Q16 modulus/outputs, 8Q24 angle
    localparam int unsigned INT_W  = 34;   // internal datapath width (2 guard bits)
    localparam int unsigned PROD_W = 66;   // signed modulus x unsigned gain product
    localparam int unsigned ITER_N = 32;   // CORDIC micro-rotations per operation
    localparam int unsigned IDX_W  = 5;    // iteration index width

    // CORDIC gain compensation, round(0.6072529350 * 2^32), unsigned 0Q32
    localparam logic [DATA_W-1:0] CORDIC_K = 32'h9B74_EDA8;

    // Quadrant folding constants in 8Q24 degrees
    localparam logic signed [INT_W-1:0] ANG_P90 = 34'sd1509949440;
    localparam logic signed [INT_W-1:0] ANG_M90 = -34'sd1509949440;
    localparam logic signed [INT_W-1:0] ANG_180 = 34'sd3019898880;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESCALE = 2'd1,
        ST_ITER     = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // Request payload: modulus (16Q16) and angle (8Q24 degrees)
    typedef struct packed {
        logic [DATA_W-1:0] mod;
        logic [DATA_W-1:0] angle;
    } p2r_req_t;

    // Result payload: rectangular components (16Q16)
    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
    } p2r_res_t;

    // Sign-extend a 32-bit word into the internal datapath width
    function automatic logic signed [INT_W-1:0] sext_int(input logic [DATA_W-1:0] v);
        return INT_W'($signed(v));
    endfunction

endpackage

// File: rtl/pol2rec_if.sv
// pol2rec_if: control/data bundle between a requester (master) and the
// pol2rec rotator (slave).
//   enable : global iteration enable       start : one-cycle request
//   req    : modulus + angle payload       res   : x/y result payload
//   busy   : rotator not idle              done  : result-valid pulse
interface pol2rec_if;
    import pol2rec_pkg::*;

    logic     enable;
    logic     start;
    p2r_req_t req;
    p2r_res_t res;
    logic     busy;
    logic     done;

    modport master (output enable, start, req, input res, busy, done);
    modport slave  (input enable, start, req, output res, busy, done);
endinterface

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut: combinational table of atan(2^-idx) in degrees, 8Q24, rounded.
//   idx    : iteration index 0..31
//   atan_c : elementary rotation angle for that index
module cordic_atan_lut
    import pol2rec_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] atan_c
);

    always_comb begin
        atan_c = '0;
        case (idx)
            5'd0:  atan_c = 32'd754974720;
            5'd1:  atan_c = 32'd445687602;
            5'd2:  atan_c = 32'd235489088;
            5'd3:  atan_c = 32'd119537938;
            5'd4:  atan_c = 32'd60000934;
            5'd5:  atan_c = 32'd30029717;
            5'd6:  atan_c = 32'd15018523;
            5'd7:  atan_c = 32'd7509720;
            5'd8:  atan_c = 32'd3754917;
            5'd9:  atan_c = 32'd1877466;
            5'd10: atan_c = 32'd938734;
            5'd11: atan_c = 32'd469367;
            5'd12: atan_c = 32'd234684;
            5'd13: atan_c = 32'd117342;
            5'd14: atan_c = 32'd58671;
            5'd15: atan_c = 32'd29335;
            5'd16: atan_c = 32'd14668;
            5'd17: atan_c = 32'd7334;
            5'd18: atan_c = 32'd3667;
            5'd19: atan_c = 32'd1833;
            5'd20: atan_c = 32'd917;
            5'd21: atan_c = 32'd458;
            5'd22: atan_c = 32'd229;
            5'd23: atan_c = 32'd115;
            5'd24: atan_c = 32'd57;
            5'd25: atan_c = 32'd29;
            5'd26: atan_c = 32'd14;
            5'd27: atan_c = 32'd7;
            5'd28: atan_c = 32'd4;
            5'd29: atan_c = 32'd2;
            5'd30: atan_c = 32'd1;
            5'd31: atan_c = 32'd0;
            default: atan_c = '0;
        endcase
    end

endmodule

// File: rtl/pol2rec.sv
// pol2rec: iterative CORDIC rotator converting (modulus, angle) to (x, y).
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pol2rec_if slave port -- enable/start/req in, res/busy/done out
// One operation: capture, gain prescale + quadrant fold, 32 micro-rotations,
// then a one-cycle done pulse with x/y updated on the same edge.
module pol2rec
    import pol2rec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    pol2rec_if.slave    bus
);

    state_e                    state_q, state_d;
    logic        [IDX_W-1:0]   i_q, i_d;
    logic signed [INT_W-1:0]   xr_q, xr_d;
    logic signed [INT_W-1:0]   yr_q, yr_d;
    logic signed [INT_W-1:0]   zr_q, zr_d;
    logic signed [DATA_W-1:0]  mod_q, mod_d;
    logic        [DATA_W-1:0]  angle_q, angle_d;
    logic        [DATA_W-1:0]  x_q, x_d;
    logic        [DATA_W-1:0]  y_q, y_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic        [DATA_W-1:0]  atan_c;
    logic signed [INT_W-1:0]   atan_ext;
    logic signed [PROD_W-1:0]  prod;
    logic signed [INT_W-1:0]   xk;
    logic signed [INT_W-1:0]   angle_ext;
    logic signed [INT_W-1:0]   xsh, ysh;
    logic signed [INT_W-1:0]   xr_n, yr_n, zr_n;
    logic                      d_pos;

    cordic_atan_lut u_atan_lut (
        .idx    (i_q),
        .atan_c (atan_c)
    );

    // Gain-compensated modulus: mod * K >>> 32
    always_comb begin
        prod      = PROD_W'(mod_q) * $signed(PROD_W'(CORDIC_K));
        xk        = INT_W'(prod >>> 32);
        angle_ext = sext_int(angle_q);
    end

    // One micro-rotation; direction follows the sign of the residual angle
    always_comb begin
        d_pos    = ~zr_q[INT_W-1];
        atan_ext = $signed(INT_W'(atan_c));
        xsh      = xr_q >>> i_q;
        ysh      = yr_q >>> i_q;
        xr_n     = d_pos ? (xr_q - ysh)      : (xr_q + ysh);
        yr_n     = d_pos ? (yr_q + xsh)      : (yr_q - xsh);
        zr_n     = d_pos ? (zr_q - atan_ext) : (zr_q + atan_ext);
    end

    // Next-state and register-update logic; nothing moves while enable is low
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        zr_d    = zr_q;
        mod_d   = mod_q;
        angle_d = angle_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = done_q;

        if (bus.enable) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_PRESCALE;
                        mod_d   = bus.req.mod;
                        angle_d = bus.req.angle;
                    end
                end
                ST_PRESCALE: begin
                    yr_d    = '0;
                    i_d     = '0;
                    state_d = ST_ITER;
                    // Fold angles beyond +/-90 deg into range by flipping the start vector
                    if (angle_ext > ANG_P90) begin
                        xr_d = -xk;
                        zr_d = angle_ext - ANG_180;
                    end else if (angle_ext < ANG_M90) begin
                        xr_d = -xk;
                        zr_d = angle_ext + ANG_180;
                    end else begin
                        xr_d = xk;
                        zr_d = angle_ext;
                    end
                end
                ST_ITER: begin
                    xr_d = xr_n;
                    yr_d = yr_n;
                    zr_d = zr_n;
                    i_d  = i_q + IDX_W'(1);
                    if (i_q == IDX_W'(ITER_N - 1)) begin
                        state_d = ST_DONE;
                        x_d     = DATA_W'(xr_n);
                        y_d     = DATA_W'(yr_n);
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            zr_q    <= '0;
            mod_q   <= '0;
            angle_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            zr_q    <= zr_d;
            mod_q   <= mod_d;
            angle_q <= angle_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.res.x = x_q;
    assign bus.res.y = y_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: doc/pol2rec.md
POL2REC -- requirements
Module: pol2rec

Interface
REQ-001 The block SHALL have no parameters; the iteration count (32) and the gain constant SHALL be fixed constants defined in the shared package.
REQ-002 clock  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  iteration enable; while low, all state SHALL hold.
REQ-005 start  input  1  one-cycle request; sampled only in IDLE with enable high.
REQ-006 mod  input  32  signed modulus, 16Q16; valid range [0, 32767].
REQ-007 angle  input  32  signed angle in degrees, 8Q24; full range [-128, 128).
REQ-008 x  output  32  signed X component, 16Q16; registered.
REQ-009 y  output  32  signed Y component, 16Q16; registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse marking new x/y.

Function
REQ-012 The block SHALL implement CORDIC rotation mode, returning x = mod·cos(angle) and y = mod·sin(angle).
REQ-013 The FSM SHALL have four states, IDLE, PRESCALE, ITER and DONE, advancing only when enable is high.
REQ-014 Transition IDLE->PRESCALE SHALL occur on start=1, capturing mod and angle into internal registers.
REQ-015 In PRESCALE, xr SHALL be loaded with mod·K, where K = round(0.6072529350·2^32) as unsigned 0Q32, product arithmetically shifted right 32 and held as 34-bit signed; yr SHALL be loaded with 0; the iteration counter i SHALL be cleared to 0.
REQ-016 Quadrant pre-rotation SHALL apply in PRESCALE: angle > +90° -> xr negated, zr = angle − 180°; angle < −90° -> xr negated, zr = angle + 180°; otherwise zr = angle.
REQ-017 Each ITER cycle SHALL compute d = +1 if zr ≥ 0 else −1, then xr' = xr − d·(yr>>>i), yr' = yr + d·(xr>>>i), zr' = zr − d·atan(2^-i), and increment i.
REQ-018 ITER->DONE SHALL occur on the cycle that performs i=31; that same edge SHALL load x = xr'[31:0] and y = yr'[31:0] and assert done.
REQ-019 DONE->IDLE SHALL occur on the next enabled edge, which deasserts done.
REQ-020 Latency with enable held high: start sampled at edge t0 -> done high between edges t0+33 and t0+34.
REQ-021 start outside IDLE SHALL be ignored, with no restart and no queueing.
REQ-022 While enable is low, state, counter, datapath registers and done SHALL hold, so a pending done pulse is stretched.
REQ-023 x and y SHALL hold their last result until the next DONE.
REQ-024 Negative mod SHALL need no special handling; the result is the negated vector.
REQ-025 Error SHALL be ≤ 16 LSB per output for inputs in range.

Reset
REQ-026 reset low SHALL asynchronously force IDLE, i=0, xr=yr=zr=0, x=y=0, busy=0 and done=0, including in the middle of an operation.
REQ-027 After reset, the first start SHALL be accepted no earlier than the first rising edge with reset high.

Structure
REQ-028 The shared package SHALL hold the state enumeration, ITER_N=32, the K constant, the ±90°/180° constants in 8Q24, and the 34-bit internal width.
REQ-029 A single sub-module, cordic_atan_lut, SHALL be combinational: a 5-bit index maps to atan(2^-i) in degrees, 8Q24, rounded.

Verification
REQ-030 mod=0x00010000, angle=0x00000000 -> x≈0x00010000, y≈0x00000000, with done 33 cycles after start.
REQ-031 mod=0x00640000, angle=0x5A000000 (90°) -> x≈0x00000000, y≈0x00640000.
REQ-032 mod=0x00020000, angle=0x78000000 (120°) -> x≈0xFFFF0000, y≈0x0001BB68.
REQ-033 mod=0x00010000, angle=0x80000000 (−128°) -> x≈0xFFFF6264, y≈0xFFFF3645.
REQ-034 Stimulus: start re-pulsed at cycle 10; enable low for cycles 15–19. Required response: the re-pulse is ignored, done arrives 5 cycles late, and the result is identical to the unstalled run.
REQ-035 Reset low at ITER cycle 20 -> busy, done, x and y read 0 immediately, without waiting for a clock edge; the next start gives a correct result.
